// File: rtl/replica_route_capture_if.sv
// Bus bundle for the replica route capture block.
//   master : host / producer side (drives start, route beats, read requests)
//   slave  : capture block side (drives status flags and read data)
// Signals:
//   start, in_valid, in_data           route stream and arm pulse
//   busy, done, dup_err, range_err,
//   to_err                             capture status
//   rd_en, rd_addr, rd_valid, rd_data  1-cycle-latency buffer read port
interface replica_route_capture_if #(
    parameter int CITY_NUM = 30,
    parameter int DATA_W   = 8
);
    localparam int AW = $clog2(CITY_NUM);

    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              busy;
    logic              done;
    logic              dup_err;
    logic              range_err;
    logic              to_err;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output start, in_valid, in_data, rd_en, rd_addr,
        input  busy, done, dup_err, range_err, to_err, rd_valid, rd_data
    );

    modport slave (
        input  start, in_valid, in_data, rd_en, rd_addr,
        output busy, done, dup_err, range_err, to_err, rd_valid, rd_data
    );
endinterface

// File: rtl/replica_route_capture.sv
// Consumer end of the replica route stream. Captures one route of CITY_NUM
// valid beats into a local buffer, checks it is a permutation of
// 0..CITY_NUM-1 and exposes the buffer through a registered read port.
// Ports:
//   clk    clock
//   reset  asynchronous, active-low reset
//   bus    replica_route_capture_if.slave (stream in, status out, read port)
module replica_route_capture #(
    parameter int CITY_NUM = 30,
    parameter int DATA_W   = 8,
    parameter int TIMEOUT  = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    replica_route_capture_if.slave   bus
);
    localparam int AW     = $clog2(CITY_NUM);
    localparam int CNT_W  = $clog2(CITY_NUM + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q;
    logic [IDLE_W-1:0]   idle_q;
    logic [CITY_NUM-1:0] seen_q;
    logic [DATA_W-1:0]   buf_q [CITY_NUM];

    logic busy_q, done_q, dup_q, range_q, to_q;
    logic rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;

    logic accept;     // beat stored this cycle
    logic timeout;    // idle limit reached this cycle
    logic in_range;
    logic dup_hit;

    // ------------------------------------------------------------------
    // Beat classification
    // ------------------------------------------------------------------
    assign in_range = (bus.in_data < DATA_W'(CITY_NUM));

    always_comb begin
        dup_hit = 1'b0;
        for (int i = 0; i < CITY_NUM; i++) begin
            if (bus.in_data == DATA_W'(i) && seen_q[i])
                dup_hit = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state. start wins over everything, including a beat
    // presented in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        timeout = 1'b0;
        if (bus.start) begin
            state_d = S_ARMED;
        end else begin
            unique case (state_q)
                S_ARMED: begin
                    if (bus.in_valid) begin
                        accept  = 1'b1;
                        state_d = (count_q == CNT_W'(CITY_NUM - 1)) ? S_DONE : S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (bus.in_valid) begin
                        accept = 1'b1;
                        if (count_q == CNT_W'(CITY_NUM - 1))
                            state_d = S_DONE;
                    end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                        // this idle cycle brings the counter to TIMEOUT
                        timeout = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // Counters, bitmap, status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            idle_q  <= '0;
            seen_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dup_q   <= 1'b0;
            range_q <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            busy_q <= (state_d == S_ARMED) || (state_d == S_CAPTURE);
            done_q <= (state_d == S_DONE);
            if (bus.start) begin
                count_q <= '0;
                idle_q  <= '0;
                seen_q  <= '0;
                dup_q   <= 1'b0;
                range_q <= 1'b0;
                to_q    <= 1'b0;
            end else if (accept) begin
                count_q <= count_q + 1'b1;
                idle_q  <= '0;
                if (!in_range)    range_q <= 1'b1;
                else if (dup_hit) dup_q   <= 1'b1;
                for (int i = 0; i < CITY_NUM; i++) begin
                    if (bus.in_data == DATA_W'(i))
                        seen_q[i] <= 1'b1;
                end
            end else if (state_q == S_CAPTURE) begin
                if (idle_q != '1)
                    idle_q <= idle_q + 1'b1;
                if (timeout)
                    to_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Route buffer (not reset) and read port. The read samples buf_q
    // before the same-edge write lands, so read/write collisions return
    // the old data.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept)
            buf_q[count_q[AW-1:0]] <= bus.in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                if ({1'b0, bus.rd_addr} < (AW + 1)'(CITY_NUM))
                    rd_data_q <= buf_q[bus.rd_addr];
                else
                    rd_data_q <= '0;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.dup_err   = dup_q;
    assign bus.range_err = range_q;
    assign bus.to_err    = to_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
endmodule
